game_tick_scheduler: RTL and testbench

- Sequences one game frame per tick from the board clock: sample inputs, request a physics update, request a collision check, then commit the frame during VGA vertical blank.
- Also produces the pixel clock-enable strobe for the VGA path.
- Sits between the clock divider and the game-logic/VGA datapaths as their single timing controller.

---
 rtl/game_tick_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_game_tick_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: frame sequencer and pixel-enable generator.
// Each game tick runs one frame sequence: sample inputs, request a physics
// update, request a collision check, wait for vertical blank, then commit.
// Also divides boardCLK down to the one-cycle pix_en strobe for the VGA path.
// Optional feature macro: GAME_TICK_WATCHDOG_EN (per-wait-state watchdog that
// aborts a stuck sequence and raises the sticky wdog_flag).
module game_tick_scheduler #(
  parameter int PIX_DIV     = 4,
  parameter int TICK_DIV    = 1666666,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic        boardCLK,
  input  logic        reset,
  input  logic        pause,
  input  logic        vblank,
  input  logic        update_done,
  input  logic        check_done,
  output logic        pix_en,
  output logic        sample_stb,
  output logic        update_req,
  output logic        check_req,
  output logic        commit_stb,
  output logic        busy,
  output logic [15:0] frame_num,
  output logic [7:0]  overrun_cnt,
  output logic        wdog_flag
);

  localparam int PIX_W  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAMPLE  = 3'd1,
    UPDATE  = 3'd2,
    CHECK   = 3'd3,
    WAIT_VB = 3'd4,
    COMMIT  = 3'd5
  } state_t;

  state_t state_reg, state_next;

  logic [PIX_W-1:0]  pix_cnt_reg, pix_cnt_next;
  logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
  logic              tick;
  logic              wdog_expired;

  logic sample_stb_next;
  logic update_req_next;
  logic check_req_next;
  logic commit_stb_next;
  logic busy_next;

  // Pixel divider: free-running modulo-PIX_DIV count
  always_comb begin
    pix_cnt_next = (pix_cnt_reg == PIX_LAST) ? '0 : pix_cnt_reg + 1'b1;
  end

  // Pixel counter and its strobe; pix_en is high while the count sits at its last value
  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      pix_cnt_reg <= '0;
      pix_en      <= 1'b0;
    end else begin
      pix_cnt_reg <= pix_cnt_next;
      pix_en      <= (pix_cnt_next == PIX_LAST);
    end
  end

  // Tick divider: modulo-TICK_DIV count that freezes while paused
  always_comb begin
    tick_cnt_next = tick_cnt_reg;
    if (!pause) begin
      tick_cnt_next = (tick_cnt_reg == TICK_LAST) ? '0 : tick_cnt_reg + 1'b1;
    end
  end

  // A paused terminal count never fires, so pause suppresses future ticks only
  assign tick = !pause && (tick_cnt_reg == TICK_LAST);

  // Tick counter register
  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_next;
    end
  end

`ifdef GAME_TICK_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt_reg;
  logic              wdog_flag_reg;

  // Counter reads 0 on the first cycle of every state and counts cycles spent there
  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      wdog_cnt_reg <= '0;
    end else if (state_next == state_reg) begin
      wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
    end else begin
      wdog_cnt_reg <= '0;
    end
  end

  assign wdog_expired = (wdog_cnt_reg == WDOG_LAST);

  // Sticky trip flag: a wait state falling back to IDLE can only be a watchdog abort
  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      wdog_flag_reg <= 1'b0;
    end else if (wdog_expired && (state_next == IDLE) &&
                 (state_reg inside {UPDATE, CHECK, WAIT_VB})) begin
      wdog_flag_reg <= 1'b1;
    end
  end

  assign wdog_flag = wdog_flag_reg;
`else
  // Watchdog absent: wait states block indefinitely and the flag never rises
  assign wdog_expired = 1'b0;
  assign wdog_flag    = (WDOG_CYCLES < 0);
`endif

  // FSM state register
  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state; a normal handshake exit takes priority over a watchdog abort
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (tick) state_next = SAMPLE;
      end
      SAMPLE: begin
        state_next = UPDATE;
      end
      UPDATE: begin
        if (update_done)       state_next = CHECK;
        else if (wdog_expired) state_next = IDLE;
      end
      CHECK: begin
        if (check_done)        state_next = WAIT_VB;
        else if (wdog_expired) state_next = IDLE;
      end
      WAIT_VB: begin
        if (vblank)            state_next = COMMIT;
        else if (wdog_expired) state_next = IDLE;
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM output decode of the state being entered, so registered outputs align with the state
  always_comb begin
    sample_stb_next = (state_next == SAMPLE);
    update_req_next = (state_next == UPDATE);
    check_req_next  = (state_next == CHECK);
    commit_stb_next = (state_next == COMMIT);
    busy_next       = (state_next != IDLE);
  end

  // Registered outputs plus frame and dropped-tick bookkeeping
  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      sample_stb  <= 1'b0;
      update_req  <= 1'b0;
      check_req   <= 1'b0;
      commit_stb  <= 1'b0;
      busy        <= 1'b0;
      frame_num   <= 16'd0;
      overrun_cnt <= 8'd0;
    end else begin
      sample_stb <= sample_stb_next;
      update_req <= update_req_next;
      check_req  <= check_req_next;
      commit_stb <= commit_stb_next;
      busy       <= busy_next;
      if (state_reg == COMMIT) begin
        frame_num <= frame_num + 16'd1;
      end
      if (tick && (state_reg != IDLE) && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Testbench for game_tick_scheduler: directed scenarios plus randomized
// inputs, checked every cycle against a behavioural frame-sequence model.
`timescale 1ns/1ps
module tb_game_tick_scheduler;

  localparam int PIX_DIV     = 4;
  localparam int TICK_DIV    = 20;
  localparam int WDOG_CYCLES = 10;

  localparam int S_IDLE    = 0;
  localparam int S_SAMPLE  = 1;
  localparam int S_UPDATE  = 2;
  localparam int S_CHECK   = 3;
  localparam int S_WAIT_VB = 4;
  localparam int S_COMMIT  = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pause = 1'b0;
  logic        vblank = 1'b0;
  logic        update_done = 1'b0;
  logic        check_done = 1'b0;
  logic        pix_en, sample_stb, update_req, check_req, commit_stb, busy, wdog_flag;
  logic [15:0] frame_num;
  logic [7:0]  overrun_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: elapsed edges, unpaused edges, sequence stage, counters
  int m_edges  = 0;
  int m_active = 0;
  int m_stage  = S_IDLE;
  int m_frame  = 0;
  int m_ovr    = 0;
  int m_dwell  = 0;
  bit m_wdog   = 1'b0;

  always #5 clk = ~clk;

  game_tick_scheduler #(
    .PIX_DIV    (PIX_DIV),
    .TICK_DIV   (TICK_DIV),
    .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .boardCLK   (clk),
    .reset      (reset),
    .pause      (pause),
    .vblank     (vblank),
    .update_done(update_done),
    .check_done (check_done),
    .pix_en     (pix_en),
    .sample_stb (sample_stb),
    .update_req (update_req),
    .check_req  (check_req),
    .commit_stb (commit_stb),
    .busy       (busy),
    .frame_num  (frame_num),
    .overrun_cnt(overrun_cnt),
    .wdog_flag  (wdog_flag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: advances on each rising edge from the inputs present at that edge
  initial begin : model
    int prev;
    bit tk;
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_edges = 0; m_active = 0; m_stage = S_IDLE;
        m_frame = 0; m_ovr = 0; m_dwell = 0; m_wdog = 1'b0;
      end else begin
        tk = ((m_active % TICK_DIV) == TICK_DIV - 1) && !pause;
        if (!pause) m_active++;
        m_edges++;
        prev = m_stage;
        if (tk && prev != S_IDLE && m_ovr < 255) m_ovr++;
        case (prev)
          S_IDLE:    if (tk) m_stage = S_SAMPLE;
          S_SAMPLE:  m_stage = S_UPDATE;
          S_UPDATE:  if (update_done) m_stage = S_CHECK;
          S_CHECK:   if (check_done) m_stage = S_WAIT_VB;
          S_WAIT_VB: if (vblank) m_stage = S_COMMIT;
          default: begin
            m_stage = S_IDLE;
            m_frame = (m_frame + 1) % 65536;
          end
        endcase
`ifdef GAME_TICK_WATCHDOG_EN
        if (m_stage == prev && prev >= S_UPDATE && prev <= S_WAIT_VB &&
            m_dwell == WDOG_CYCLES - 1) begin
          m_stage = S_IDLE;
          m_wdog  = 1'b1;
        end
`endif
        m_dwell = (m_stage == prev) ? m_dwell + 1 : 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  initial begin : compare
    forever begin
      @(posedge clk);
      #2;
      chk("pix_en",      pix_en,      (m_edges % PIX_DIV) == PIX_DIV - 1);
      chk("sample_stb",  sample_stb,  m_stage == S_SAMPLE);
      chk("update_req",  update_req,  m_stage == S_UPDATE);
      chk("check_req",   check_req,   m_stage == S_CHECK);
      chk("commit_stb",  commit_stb,  m_stage == S_COMMIT);
      chk("busy",        busy,        m_stage != S_IDLE);
      chk("frame_num",   frame_num,   m_frame);
      chk("overrun_cnt", overrun_cnt, m_ovr);
      chk("wdog_flag",   wdog_flag,   m_wdog);
    end
  end

  initial begin : stim
    int first_pix, first_smp, first_cmt, second_cmt, cnt;
    bit found;

    reset = 1'b0; pause = 1'b0; vblank = 1'b1; update_done = 1'b1; check_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {pix_en, sample_stb, update_req, check_req, commit_stb, busy,
                        wdog_flag, frame_num, overrun_cnt}, 0);
    reset = 1'b1;

    // Free run with all handshakes high: ticks at cycles 19 and 39
    first_pix = -1; first_smp = -1; first_cmt = -1; second_cmt = -1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (pix_en && first_pix < 0) first_pix = c;
      if (sample_stb && first_smp < 0) first_smp = c;
      if (commit_stb) begin
        if (first_cmt < 0) first_cmt = c;
        else if (second_cmt < 0) second_cmt = c;
      end
      if (c == 25) chk("frame_after_first_commit", frame_num, 1);
    end
    chk("first_pix_en_cycle", first_pix, 3);
    chk("first_sample_cycle", first_smp, 20);
    chk("first_commit_cycle", first_cmt, 24);
    chk("second_commit_cycle", second_cmt, 44);
    chk("frame_after_two", frame_num, 2);

    // Stalled physics update: the tick during the stall is dropped
    update_done = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (update_req) found = 1'b1;
    end
    chk("wait_update_req", found, 1);
    repeat (30) @(negedge clk);
`ifndef GAME_TICK_WATCHDOG_EN
    chk("update_req_held", update_req, 1);
    chk("overrun_one", overrun_cnt, 1);
`endif
    update_done = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (commit_stb) found = 1'b1;
    end
    chk("wait_commit_after_update", found, 1);
    @(negedge clk);
    chk("frame_after_stall", frame_num, 3);

    // Late vblank: commit exactly one cycle after vblank rises
    vblank = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (busy && !sample_stb && !update_req && !check_req && !commit_stb) found = 1'b1;
    end
    chk("wait_vb_entry", found, 1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("no_commit_before_vblank", commit_stb, 0);
    end
    vblank = 1'b1;
    @(negedge clk);
    chk("commit_after_vblank", commit_stb, 1);

    // Pause from tick count 12 for 50 cycles: tick arrives 7 cycles after release
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if ((m_active % TICK_DIV) == 12 && !busy) found = 1'b1;
    end
    chk("wait_tick_cnt_12", found, 1);
    pause = 1'b1;
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (sample_stb) cnt++;
    end
    chk("no_sample_while_paused", cnt, 0);
    pause = 1'b0;
    cnt = -1;
    for (int k = 1; k <= 20 && cnt < 0; k++) begin
      @(negedge clk);
      if (sample_stb) cnt = k;
    end
    chk("sample_after_unpause", cnt, 8);
    repeat (8) @(negedge clk);

    // Stalled collision check, then an asynchronous reset in the middle of CHECK
    check_done = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (check_req) found = 1'b1;
    end
    chk("wait_check_req", found, 1);
`ifdef GAME_TICK_WATCHDOG_EN
    cnt = 1;
    for (int k = 0; k < 30 && check_req; k++) begin
      @(negedge clk);
      if (check_req) cnt++;
    end
    chk("wdog_check_cycles", cnt, WDOG_CYCLES);
    chk("wdog_flag_set", wdog_flag, 1);
    chk("wdog_frame_kept", frame_num, 4);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (check_req) found = 1'b1;
    end
    chk("wait_check_req_again", found, 1);
`endif
    repeat (2) @(negedge clk);
    chk("check_req_stalled", check_req, 1);
    reset = 1'b0;
    #1;
    chk("async_reset_clears", {pix_en, sample_stb, update_req, check_req, commit_stb, busy,
                               wdog_flag, frame_num, overrun_cnt}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_done = 1'b1;

    // Permanent update stall: dropped ticks saturate the overrun counter
    update_done = 1'b0;
    repeat (260 * TICK_DIV + 30) @(negedge clk);
`ifndef GAME_TICK_WATCHDOG_EN
    chk("overrun_saturated", overrun_cnt, 255);
`endif
    update_done = 1'b1;

    // Randomized handshakes, vblank, pause and two short reset pulses
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      update_done = ($urandom_range(0, 3) == 0);
      check_done  = ($urandom_range(0, 3) == 0);
      vblank      = ($urandom_range(0, 7) < 3);
      if ($urandom_range(0, 99) == 0) pause = ~pause;
      reset = (i == 1500 || i == 2400) ? 1'b0 : 1'b1;
    end
    pause = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
